// File: rtl/core_pkg.sv
// core_pkg: shared fetch constants and state type for core_v1
package core_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int IMEM_BYTES_DEFAULT = 256;
    typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_e;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: next-pc, fetch legality and next fetch state
module fetch_next_pc
    import core_pkg::*;
#(
    parameter int IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
    input  logic [31:0]  pc_i,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_pc_i,
    input  logic         stall_i,
    input  fetch_state_e state_i,
    output logic [31:0]  next_pc_o,
    output logic [31:0]  target_o,
    output logic         legal_o,
    output fetch_state_e next_state_o
);
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);
    logic run;
    logic take;
    // candidate address is the redirect target or the sequential pc, checked over all 32 bits
    always_comb begin
        run          = state_i == RUN;
        target_o     = (run && redirect_valid_i) ? redirect_pc_i : pc_i + 32'd4;
        legal_o      = target_o[1:0] == 2'b00 && target_o <= LAST_PC;
        take         = run && (redirect_valid_i || !stall_i);
        next_pc_o    = (take && legal_o) ? target_o : pc_i;
        next_state_o = (state_i == BOOT) ? RUN : (take && !legal_o) ? FAULT : state_i;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, IF/ID register and sticky fetch fault
module instr_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        fault,
    output logic [31:0] fault_pc
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, target;
    logic         legal;
    logic         id_valid_q, fault_q;
    logic [31:0]  id_pc_q, id_instr_q, fault_pc_q;

    fetch_next_pc #(.IMEM_BYTES(IMEM_BYTES)) u_next (
        .pc_i             (pc_q),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .stall_i          (stall),
        .state_i          (state_q),
        .next_pc_o        (pc_d),
        .target_o         (target),
        .legal_o          (legal),
        .next_state_o     (state_d)
    );

    // fetch FSM: redirect flushes, stall holds, otherwise deliver and advance; FAULT only drains
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == RUN) begin
                if (redirect_valid) begin
                    id_valid_q <= 1'b0;
                end else if (!stall) begin
                    id_valid_q <= 1'b1;
                    id_pc_q    <= pc_q;
                    id_instr_q <= imem_instr;
                end
                if ((redirect_valid || !stall) && !legal) begin
                    fault_q    <= 1'b1;
                    fault_pc_q <= target;
                end
            end else if (state_q == FAULT && !stall) begin
                id_valid_q <= 1'b0;
            end
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: vector table, hand sequences and randomized model check of instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        id_valid, fault;
    logic [31:0] id_pc, id_instr, fault_pc;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h00100e13 + (a << 12);
    endfunction

    assign imem_instr = rom_word(imem_addr);

    // reference model: phase 0 boot, 1 running, 2 faulted
    int          m_phase;
    logic [31:0] m_pc, m_idpc, m_instr, m_fpc;
    bit          m_valid, m_fault;

    function automatic bit fetch_ok(input logic [31:0] a);
        return (a % 4 == 0) && (longint'(a) <= 64'd252);
    endfunction

    task automatic model_step(input bit r, input bit rv, input logic [31:0] rp, input bit st);
        if (r) begin
            m_phase = 0; m_pc = 0; m_valid = 0; m_idpc = 0; m_instr = 32'h13; m_fault = 0; m_fpc = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (rv) begin
                m_valid = 0;
                if (fetch_ok(rp)) m_pc = rp;
                else begin m_phase = 2; m_fault = 1; m_fpc = rp; end
            end else if (!st) begin
                m_valid = 1; m_idpc = m_pc; m_instr = rom_word(m_pc);
                if (fetch_ok(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
                else begin m_phase = 2; m_fault = 1; m_fpc = m_pc + 32'd4; end
            end
        end else if (!st) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit rv, input logic [31:0] rp, input bit st);
        rst = r; redirect_valid = rv; redirect_pc = rp; stall = st;
        @(posedge clk);
        #1;
        model_step(r, rv, rp, st);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(m_valid));
        chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
        chk({tag, ".fault_pc"}, fault_pc, m_fpc);
        if (m_valid) begin
            chk({tag, ".id_pc"}, id_pc, m_idpc);
            chk({tag, ".id_instr"}, id_instr, m_instr);
        end
    endtask

    typedef struct {
        bit          r, rv, st;
        logic [31:0] rpc;
        bit          v;
        logic [31:0] ipc, addr;
        bit          f;
        logic [31:0] fpc;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(bit r, bit rv, logic [31:0] rpc, bit st, bit v, logic [31:0] ipc,
                                logic [31:0] addr, bit f, logic [31:0] fpc);
        vec_t x;
        x.r = r; x.rv = rv; x.rpc = rpc; x.st = st; x.v = v; x.ipc = ipc; x.addr = addr; x.f = f; x.fpc = fpc;
        return x;
    endfunction

    initial begin
        vt[0]  = mk(1, 0, 0,     0, 0, 0,  0,  0, 0);
        vt[1]  = mk(1, 0, 0,     0, 0, 0,  0,  0, 0);
        vt[2]  = mk(0, 1, 32'h8, 0, 0, 0,  0,  0, 0);
        vt[3]  = mk(0, 0, 0,     0, 1, 0,  4,  0, 0);
        vt[4]  = mk(0, 0, 0,     0, 1, 4,  8,  0, 0);
        vt[5]  = mk(0, 0, 0,     0, 1, 8,  12, 0, 0);
        vt[6]  = mk(0, 0, 0,     1, 1, 8,  12, 0, 0);
        vt[7]  = mk(0, 0, 0,     1, 1, 8,  12, 0, 0);
        vt[8]  = mk(0, 0, 0,     1, 1, 8,  12, 0, 0);
        vt[9]  = mk(0, 0, 0,     0, 1, 12, 16, 0, 0);
        vt[10] = mk(0, 0, 0,     0, 1, 16, 20, 0, 0);
        vt[11] = mk(0, 0, 0,     0, 1, 20, 24, 0, 0);
        vt[12] = mk(0, 0, 0,     0, 1, 24, 28, 0, 0);
        vt[13] = mk(0, 0, 0,     0, 1, 28, 32, 0, 0);
        vt[14] = mk(0, 0, 0,     0, 1, 32, 36, 0, 0);
        vt[15] = mk(0, 0, 0,     0, 1, 36, 40, 0, 0);
        vt[16] = mk(0, 1, 32'h4, 0, 0, 36, 4,  0, 0);
        vt[17] = mk(0, 0, 0,     0, 1, 4,  8,  0, 0);
        vt[18] = mk(0, 1, 32'h10,1, 0, 4,  16, 0, 0);
        vt[19] = mk(0, 0, 0,     0, 1, 16, 20, 0, 0);
        vt[20] = mk(0, 0, 0,     0, 1, 20, 24, 0, 0);
        vt[21] = mk(0, 1, 32'h6, 0, 0, 20, 24, 1, 6);
        vt[22] = mk(0, 1, 32'h0, 0, 0, 20, 24, 1, 6);
        vt[23] = mk(0, 0, 0,     1, 0, 20, 24, 1, 6);

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            cycle(vt[i].r, vt[i].rv, vt[i].rpc, vt[i].st);
            chk($sformatf("vec%0d.imem_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("vec%0d.id_valid", i), 32'(id_valid), 32'(vt[i].v));
            chk($sformatf("vec%0d.fault", i), 32'(fault), 32'(vt[i].f));
            chk($sformatf("vec%0d.fault_pc", i), fault_pc, vt[i].fpc);
            if (vt[i].r || vt[i].v) chk($sformatf("vec%0d.id_pc", i), id_pc, vt[i].ipc);
            if (vt[i].r) chk($sformatf("vec%0d.id_instr", i), id_instr, 32'h0000_0013);
            else if (vt[i].v) chk($sformatf("vec%0d.id_instr", i), id_instr, rom_word(vt[i].ipc));
        end

        // run off the end of the ROM, drain under stall, then reset restarts
        cycle(1, 0, 0, 0);
        chk_model("end.rst");
        for (int i = 0; i < 80 && !fault; i++) begin
            cycle(0, 0, 0, 0);
            chk_model("end.seq");
        end
        chk("end.id_pc", id_pc, 32'd252);
        chk("end.id_valid", 32'(id_valid), 32'd1);
        chk("end.fault_pc", fault_pc, 32'd256);
        chk("end.imem_addr", imem_addr, 32'd252);
        cycle(0, 1, 32'h40, 1);
        chk("end.stall_hold", 32'(id_valid), 32'd1);
        chk("end.redir_ignored", imem_addr, 32'd252);
        cycle(0, 0, 0, 0);
        chk("end.drain", 32'(id_valid), 32'd0);
        cycle(1, 0, 0, 1);
        chk("end.fault_cleared", 32'(fault), 32'd0);
        chk("end.restart_pc", imem_addr, 32'd0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("end.first_valid", 32'(id_valid), 32'd1);
        chk("end.first_pc", id_pc, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          r, rv, st;
            logic [31:0] rp;
            int          k;
            r  = ($urandom_range(0, 99) == 0) || (m_phase == 2 && $urandom_range(0, 5) == 0);
            rv = $urandom_range(0, 7) == 0;
            st = $urandom_range(0, 3) == 0;
            k  = $urandom_range(0, 9);
            rp = (k < 7) ? 32'($urandom_range(0, 63)) * 4 :
                 (k == 7) ? 32'($urandom_range(0, 255)) :
                 (k == 8) ? 32'd256 : 32'hFFFF_FFFC;
            cycle(r, rv, rp, st);
            chk_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for core_v1. Owns the program counter, drives the byte address into the combinational instruction ROM (`instr_mem`) and registers the returned word into an IF/ID register with a valid/stall handshake toward decode. Handles redirects from branch/jump resolution, pipeline flush on redirect, and a sticky fault state for misaligned or out-of-range fetch addresses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `IMEM_BYTES`, default 256: ROM size in bytes; legal fetch PCs are 0..IMEM_BYTES-4, word-aligned.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  byte address to instr_mem; equals the `pc` register, combinationally.
- `imem_instr`  in  32  instruction word returned combinationally by instr_mem for `imem_addr`.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  target PC, sampled when `redirect_valid`=1.
- `stall`  in  1  decode not ready; hold IF/ID and PC.
- `id_valid`  out  1  IF/ID register holds a live instruction.
- `id_pc`  out  32  PC of `id_instr`.
- `id_instr`  out  32  fetched instruction.
- `fault`  out  1  sticky fetch fault; cleared only by `rst`.
- `fault_pc`  out  32  offending address latched on fault entry.

## Operation
- States: BOOT, RUN, FAULT.
- Reset values: state=BOOT, `pc`=RESET_PC, `id_valid`=0, `id_pc`=0, `id_instr`=32'h0000_0013 (NOP), `fault`=0, `fault_pc`=0.
- BOOT: exactly one cycle after `rst` deasserts. Outputs hold their reset values, inputs are ignored, then → RUN.
- RUN, per cycle, priority redirect > stall > advance:
  - Redirect, legal target (`redirect_pc[1:0]`=0 and `redirect_pc` ≤ IMEM_BYTES-4): `pc`←`redirect_pc`, `id_valid`←0 (flush, even if `stall`=1). `id_pc`/`id_instr` are don't-care-held.
  - Redirect, illegal target: → FAULT, `fault`←1, `fault_pc`←`redirect_pc`, `id_valid`←0, `pc` unchanged.
  - Stall (no redirect): `pc`, `id_*` hold.
  - Advance: `id_valid`←1, `id_pc`←`pc`, `id_instr`←`imem_instr`, `pc`←`pc`+4. If `pc`+4 > IMEM_BYTES-4: → FAULT, `fault_pc`←`pc`+4, `pc` held. The current instruction is still delivered.
- FAULT: `pc` frozen. Redirects are ignored. If `stall`=1, `id_*` hold (a pending instruction is not lost). If `stall`=0, `id_valid`←0. Only `rst` exits.
- Handshake: an instruction is consumed on any cycle with `id_valid`=1 and `stall`=0. `stall` with `id_valid`=0 is legal and freezes `pc`.
- Arithmetic: `pc`+4 is 32-bit unsigned. Range checks use the full 32 bits (no truncation to ROM index width).
- `rst` asserted in any state, mid-stall or mid-redirect: the reset values apply on the next edge.

## Timing
- Fetch latency: an instruction at `pc` appears on `id_*` one edge after `pc` is presented, with no stall.
- Redirect penalty: one bubble. The cycle after redirect has `id_valid`=0, and the target instruction is valid on the following edge.
- Throughput: one instruction per cycle with no stall or redirect.
- `imem_addr` is glitch-free relative to `clk`, because it comes straight from the register.
- First valid instruction after reset: `rst` low at edge N → BOOT; at edge N+2, `id_valid`=1 with `id_pc`=RESET_PC.

## Structure
- Shared package `core_pkg`: `NOP_INSTR`=32'h0000_0013, the fetch state enum {BOOT, RUN, FAULT}, and the `IMEM_BYTES` default constant (shared with instr_mem).
- One natural sub-module: `fetch_next_pc`, combinational. It takes `pc`, the redirect inputs, `stall` and the state, and produces the next `pc`, the legality flag and the next state.
- The top contains the `pc`, IF/ID and fault registers.

## Test plan
- Reset/boot: `rst` for 2 cycles, then imem returns 32'h00100e13 at 0 → `id_valid`=0 for the BOOT cycle, then `id_pc`=0 and `id_instr`=32'h00100e13. `pc` steps 4, 8, 12 on consecutive cycles.
- Stall: assert `stall` for 3 cycles while `id_pc`=8 → `id_pc` stays 8 and `imem_addr` stays 12. Release → `id_pc`=12 next edge.
- Redirect: at `pc`=0x28, `redirect_pc`=0x04 → next cycle `id_valid`=0 and `imem_addr`=0x04, then `id_pc`=0x04.
- Redirect with stall: `redirect_valid`=1 and `stall`=1 together → flush wins, `id_valid`=0, `pc`=target.
- Misaligned redirect to 0x06 → `fault`=1 and `fault_pc`=0x06. Later redirects are ignored, and `id_valid` falls to 0 once `stall`=0.
- Run off end: sequential fetch reaching `pc`=252 → instruction at 252 delivered, then `fault`=1 with `fault_pc`=256. `rst` clears it and restarts at RESET_PC.
